// File: rtl/tetris_pkg.sv
// Shared command codes and key-handling types for the keyboard-to-game path.
// The CMD_* codes are also decoded by GameControl.
package tetris_pkg;

  localparam logic [2:0] CMD_NONE  = 3'b000;
  localparam logic [2:0] CMD_DOWN  = 3'b100;
  localparam logic [2:0] CMD_LEFT  = 3'b101;
  localparam logic [2:0] CMD_RIGHT = 3'b110;
  localparam logic [2:0] CMD_UP    = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_SPACE = 3'd1,
    KEY_DOWN  = 3'd2,
    KEY_LEFT  = 3'd3,
    KEY_RIGHT = 3'd4,
    KEY_UP    = 3'd5
  } key_id_t;

  // Fixed priority: space > down > left > right > up.
  function automatic key_id_t pick_key(input logic space, input logic down,
                                       input logic left, input logic right,
                                       input logic up);
    key_id_t k;
    if (space)      k = KEY_SPACE;
    else if (down)  k = KEY_DOWN;
    else if (left)  k = KEY_LEFT;
    else if (right) k = KEY_RIGHT;
    else if (up)    k = KEY_UP;
    else            k = KEY_NONE;
    return k;
  endfunction

  function automatic logic [2:0] key_cmd(input key_id_t k);
    logic [2:0] c;
    case (k)
      KEY_DOWN:  c = CMD_DOWN;
      KEY_LEFT:  c = CMD_LEFT;
      KEY_RIGHT: c = CMD_RIGHT;
      KEY_UP:    c = CMD_UP;
      default:   c = CMD_NONE;
    endcase
    return c;
  endfunction

  // Mask bit order is {up, right, left, down}.
  function automatic logic key_repeats(input key_id_t k, input logic [3:0] mask);
    logic r;
    case (k)
      KEY_DOWN:  r = mask[0];
      KEY_LEFT:  r = mask[1];
      KEY_RIGHT: r = mask[2];
      KEY_UP:    r = mask[3];
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Hold counter for key auto-repeat: first fire after DAS_CYCLES of hold,
// then every ARR_CYCLES. Saturates instead of wrapping.
module key_repeat_timer
  import tetris_pkg::*;
#(
  parameter int DAS_CYCLES = 25_000_000,
  parameter int ARR_CYCLES = 5_000_000,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  input  logic       hold,
  input  logic       repeat_en,
  input  key_state_t mode,
  output logic       fire
);

  // The press cycle itself counts as the first held cycle, hence the -1.
  localparam logic [CNT_W-1:0] DAS_LIM = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LIM = CNT_W'(ARR_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

  always_comb begin
    limit = (mode == REPEAT) ? ARR_LIM : DAS_LIM;
    fire  = hold && repeat_en && (mode != IDLE) && (cnt >= limit);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (start || fire || !hold) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_command_gen.sv
// Turns level key flags into one-shot game commands with auto-repeat, a one-entry
// valid/ready command buffer, and a stretched game reset plus LED toggle on space.
module key_command_gen
  import tetris_pkg::*;
#(
  parameter int         DAS_CYCLES  = 25_000_000,
  parameter int         ARR_CYCLES  = 5_000_000,
  parameter int         RST_CYCLES  = 4,
  parameter int         CNT_W       = 32,
  parameter logic [3:0] REPEAT_MASK = 4'b0111
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       left,
  input  logic       right,
  input  logic       down,
  input  logic       up,
  input  logic       space,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       game_rst,
  output logic       led,
  output logic [1:0] dbg_state
);

  // Handshake: cmd is offered while cmd_valid=1 and is consumed on any cycle with
  // cmd_valid & cmd_ready; cmd stays stable until consumed and reads 000 when idle.

  localparam int RST_W = $clog2(RST_CYCLES + 1);

  key_state_t       state, state_nxt;
  key_id_t          act, prev_act;
  logic             space_rise, start, hold, fire, emit, repeat_en;
  logic [RST_W-1:0] rst_cnt;

  always_comb begin
    act        = pick_key(space, down, left, right, up);
    space_rise = (act == KEY_SPACE) && (prev_act != KEY_SPACE);
    start      = (act != prev_act) && (act != KEY_NONE) && (act != KEY_SPACE);
    hold       = (act == prev_act) && (act != KEY_NONE) && (act != KEY_SPACE) &&
                 (state != IDLE);
    repeat_en  = key_repeats(act, REPEAT_MASK);
    emit       = start || fire;
  end

  key_repeat_timer #(
    .DAS_CYCLES (DAS_CYCLES),
    .ARR_CYCLES (ARR_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk       (clk),
    .clrn      (clrn),
    .start     (start),
    .hold      (hold),
    .repeat_en (repeat_en),
    .mode      (state),
    .fire      (fire)
  );

  always_comb begin
    state_nxt = state;
    if ((act == KEY_NONE) || (act == KEY_SPACE)) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = DELAY;
    end else if (fire && (state == DELAY)) begin
      state_nxt = REPEAT;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      prev_act <= KEY_NONE;
    end else begin
      state    <= state_nxt;
      prev_act <= act;
    end
  end

  // Emits arriving while a command is still waiting are dropped, not queued.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cmd_valid <= 1'b0;
      cmd       <= CMD_NONE;
    end else if (space_rise) begin
      cmd_valid <= 1'b0;
      cmd       <= CMD_NONE;
    end else if (emit && (!cmd_valid || cmd_ready)) begin
      cmd_valid <= 1'b1;
      cmd       <= key_cmd(act);
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
      cmd       <= CMD_NONE;
    end
  end

  // A new space edge reloads the stretcher, restarting any pulse in progress.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rst_cnt <= '0;
      led     <= 1'b0;
    end else if (space_rise) begin
      rst_cnt <= RST_W'(RST_CYCLES);
      led     <= ~led;
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - RST_W'(1);
    end
  end

  assign game_rst  = (rst_cnt != '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_key_command_gen.sv
// Bench for key_command_gen: reset checks, a hand-written vector table, directed
// repeat/handshake/reset sequences, and random key activity against a cycle model.
module tb_key_command_gen;

  localparam int DAS  = 10;
  localparam int ARR  = 4;
  localparam int RSTC = 4;

  // Key vectors are packed {space, down, left, right, up}.
  localparam logic [4:0] K_NONE  = 5'b00000;
  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_RIGHT = 5'b00010;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_DOWN  = 5'b01000;
  localparam logic [4:0] K_SPACE = 5'b10000;

  logic       clk = 1'b0;
  logic       clrn;
  logic       left, right, down, up, space, cmd_ready;
  logic       cmd_valid, game_rst, led;
  logic [2:0] cmd;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  // Expected outputs packed {cmd_valid, cmd[2:0], game_rst, led}.
  logic [5:0] exp_q[$];

  // Reference model state: which key is on top, for how many cycles it has been held.
  int         m_prev;
  int         m_hold;
  logic       m_valid;
  logic [2:0] m_cmd;
  int         m_pulse;
  logic       m_led;

  typedef struct {
    logic [4:0] keys;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t tv[17];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  key_command_gen #(
    .DAS_CYCLES  (DAS),
    .ARR_CYCLES  (ARR),
    .RST_CYCLES  (RSTC),
    .CNT_W       (8),
    .REPEAT_MASK (4'b0111)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .left      (left),
    .right     (right),
    .down      (down),
    .up        (up),
    .space     (space),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .game_rst  (game_rst),
    .led       (led),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic int top_key(input logic [4:0] k);
    if (k[4]) return 1;
    if (k[3]) return 2;
    if (k[2]) return 3;
    if (k[1]) return 4;
    if (k[0]) return 5;
    return 0;
  endfunction

  task automatic model_reset();
    m_prev  = 0;
    m_hold  = 0;
    m_valid = 1'b0;
    m_cmd   = 3'b000;
    m_pulse = 0;
    m_led   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [4:0] k, input logic rdy);
    int         a;
    logic       em;
    logic [2:0] code;
    a    = top_key(k);
    em   = 1'b0;
    code = 3'b000;
    if (a == 1 && m_prev != 1) begin
      m_valid = 1'b0;
      m_cmd   = 3'b000;
      m_pulse = RSTC;
      m_led   = ~m_led;
    end else begin
      if (a >= 2) begin
        m_hold = (a == m_prev) ? m_hold + 1 : 0;
        em = (m_hold == 0) ||
             (a != 5 && m_hold >= DAS && ((m_hold - DAS) % ARR) == 0);
        case (a)
          2:       code = 3'b100;
          3:       code = 3'b101;
          4:       code = 3'b110;
          default: code = 3'b111;
        endcase
      end
      if (em && (!m_valid || rdy)) begin
        m_valid = 1'b1;
        m_cmd   = code;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
        m_cmd   = 3'b000;
      end
      if (m_pulse > 0) m_pulse--;
    end
    m_prev = a;
    exp_q.push_back({m_valid, m_cmd, (m_pulse != 0), m_led});
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [5:0] outs();
    return {cmd_valid, cmd, game_rst, led};
  endfunction

  task automatic check_val(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {valid,cmd,rst,led}=%b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: expected queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check_val(name, outs(), e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic [4:0] k, input logic rdy);
    {space, down, left, right, up} = k;
    cmd_ready = rdy;
    model_step(k, rdy);
    @(posedge clk);
    #1;
    check_model("model");
  endtask

  // Asserts clrn in mid-cycle, checks outputs clear at once, releases after the next edge.
  task automatic reset_mid(input string name);
    #2 clrn = 1'b0;
    #1;
    check_val(name, outs(), 6'b000000);
    model_reset();
    @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int         hits[$];
    int         cnt;
    logic [2:0] seen;
    logic [4:0] k;
    logic       r;

    // Tap left, then pending down flushed by space, then a second space press.
    tv[0]  = '{K_LEFT,          1'b1, 6'b110100};
    tv[1]  = '{K_LEFT,          1'b1, 6'b000000};
    tv[2]  = '{K_LEFT,          1'b1, 6'b000000};
    tv[3]  = '{K_NONE,          1'b1, 6'b000000};
    tv[4]  = '{K_NONE,          1'b1, 6'b000000};
    tv[5]  = '{K_DOWN,          1'b0, 6'b110000};
    tv[6]  = '{K_DOWN,          1'b0, 6'b110000};
    tv[7]  = '{K_SPACE | K_DOWN, 1'b0, 6'b000011};
    tv[8]  = '{K_SPACE,         1'b0, 6'b000011};
    tv[9]  = '{K_NONE,          1'b0, 6'b000011};
    tv[10] = '{K_NONE,          1'b0, 6'b000011};
    tv[11] = '{K_NONE,          1'b0, 6'b000001};
    tv[12] = '{K_SPACE,         1'b0, 6'b000010};
    tv[13] = '{K_NONE,          1'b0, 6'b000010};
    tv[14] = '{K_NONE,          1'b0, 6'b000010};
    tv[15] = '{K_NONE,          1'b0, 6'b000010};
    tv[16] = '{K_NONE,          1'b0, 6'b000000};

    clrn = 1'b0;
    {space, down, left, right, up} = K_NONE;
    cmd_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset", outs(), 6'b000000);
    clrn = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].keys, tv[i].rdy);
      check_val($sformatf("table[%0d]", i), outs(), tv[i].exp);
    end

    // Hold down: commands expected at cycles 1, 11, 15, 19, 23, 27.
    for (int i = 0; i < 35; i++) begin
      step((i < 30) ? K_DOWN : K_NONE, 1'b1);
      if (cmd_valid) hits.push_back(i + 1);
    end
    check_val("hold_down_count", 6'(hits.size()), 6'd6);
    if (hits.size() == 6) begin
      check_val("hold_down_c0", 6'(hits[0]), 6'd1);
      check_val("hold_down_c1", 6'(hits[1]), 6'd11);
      check_val("hold_down_c2", 6'(hits[2]), 6'd15);
      check_val("hold_down_c5", 6'(hits[5]), 6'd27);
    end

    // Hold up: rotate does not repeat.
    cnt  = 0;
    seen = 3'b000;
    for (int i = 0; i < 33; i++) begin
      step((i < 30) ? K_UP : K_NONE, 1'b1);
      if (cmd_valid) begin
        cnt++;
        seen = cmd;
      end
    end
    check_val("hold_up_count", 6'(cnt), 6'd1);
    check_val("hold_up_code", {3'b000, seen}, 6'b000111);

    // Right with ready low: one command held stable, repeats dropped.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(K_RIGHT, 1'b0);
      if (cmd_valid && cmd == 3'b110) cnt++;
    end
    check_val("stall_stable", 6'(cnt), 6'd20);
    step(K_NONE, 1'b1);
    check_val("stall_accept", outs(), 6'b000000);
    step(K_NONE, 1'b1);

    // Reset mid-repeat with left still held, then a fresh press after release.
    for (int i = 0; i < 16; i++) step(K_LEFT, 1'b1);
    reset_mid("rst_mid_repeat");
    step(K_LEFT, 1'b1);
    check_val("rst_fresh_press", outs(), 6'b110100);
    step(K_LEFT, 1'b1);
    step(K_NONE, 1'b1);

    // Reset in the middle of a game_rst pulse.
    step(K_SPACE, 1'b1);
    step(K_SPACE, 1'b1);
    reset_mid("rst_mid_pulse");
    step(K_NONE, 1'b1);
    check_val("rst_no_residual", outs(), 6'b000000);

    // Random key runs against the model.
    k = K_NONE;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0)
        k = {($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15))};
      r = ($urandom_range(0, 3) != 0);
      step(k, r);
      if ($urandom_range(0, 249) == 0) reset_mid("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
